dff_arbiter: RTL and testbench

DFF_ARBITER -- requirements
Module: dff_arbiter

---
 rtl/dff_arb_pkg.sv | 14 +
 rtl/dff_arbiter_rr_pick.sv | 30 +++
 rtl/dff_arbiter.sv | 127 ++++++++++++
 tb/tb_dff_arbiter.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/dff_arb_pkg.sv
// Shared types and default sizing for the round-robin arbitrated shared register.
package dff_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    CAPTURE = 2'd2,
    HOLD    = 2'd3
  } arb_state_t;

  localparam int DEF_NREQ = 4;
  localparam int DEF_DW   = 8;

endpackage

// File: rtl/dff_arbiter_rr_pick.sv
// Round-robin selector: first set request at or above ptr, wrapping at NREQ-1 to 0.
module rr_pick #(
  parameter int NREQ = dff_arb_pkg::DEF_NREQ,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [IW-1:0]   winner,
  output logic            valid
);

  function automatic logic [IW-1:0] wrap_idx(input logic [IW-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= NREQ) s = s - NREQ;
    return IW'(s);
  endfunction

  always_comb begin
    valid  = 1'b0;
    winner = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!valid && req[wrap_idx(ptr, k)]) begin
        valid  = 1'b1;
        winner = wrap_idx(ptr, k);
      end
    end
  end

endmodule

// File: rtl/dff_arbiter.sv
// Shared DW-bit register written by NREQ requesters under round-robin arbitration.
//   state   | meaning
//   IDLE    | no transaction; pick a winner when any req is set
//   GRANT   | gnt to winner; write q if winner still requests, else abort
//   CAPTURE | one-cycle ack to winner; q holds the new value
//   HOLD    | winner keeps req high; wait for it to drop
module dff_arbiter
  import dff_arb_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int DW   = DEF_DW
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*DW-1:0]       wdata,
  output logic [NREQ-1:0]          gnt,
  output logic [NREQ-1:0]          ack,
  output logic [DW-1:0]            q,
  output logic [DW-1:0]            qbar,
  output logic [$clog2(NREQ)-1:0]  owner,
  output logic                     busy
);

  localparam int IW = $clog2(NREQ);

  arb_state_t       r_state;
  logic [IW-1:0]    r_ptr;
  logic [IW-1:0]    r_winner;
  logic [IW-1:0]    r_owner;
  logic [NREQ-1:0]  r_gnt;
  logic [NREQ-1:0]  r_ack;
  logic [DW-1:0]    r_q;
  logic             r_busy;

  logic [IW-1:0]    w_pick_idx;
  logic             w_pick_valid;
  logic [NREQ-1:0]  w_pick_oh;
  logic [NREQ-1:0]  w_win_oh;
  logic             w_req_win;
  logic [IW-1:0]    w_next_ptr;
  logic [DW-1:0]    w_wdata_win;

  rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_rr_pick (
    .req    (req),
    .ptr    (r_ptr),
    .winner (w_pick_idx),
    .valid  (w_pick_valid)
  );

  assign w_pick_oh   = {{(NREQ-1){1'b0}}, 1'b1} << w_pick_idx;
  assign w_win_oh    = {{(NREQ-1){1'b0}}, 1'b1} << r_winner;
  assign w_req_win   = req[r_winner];
  assign w_next_ptr  = (r_winner == IW'(NREQ-1)) ? '0 : r_winner + 1'b1;
  assign w_wdata_win = wdata[r_winner*DW +: DW];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_ptr    <= '0;
      r_winner <= '0;
      r_owner  <= '0;
      r_gnt    <= '0;
      r_ack    <= '0;
      r_q      <= '0;
      r_busy   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_pick_valid) begin
            r_winner <= w_pick_idx;
            r_gnt    <= w_pick_oh;
            r_busy   <= 1'b1;
            r_state  <= GRANT;
          end
        end
        GRANT: begin
          // Pointer advances past the winner even on abort so a flaky requester cannot starve others.
          r_gnt <= '0;
          r_ptr <= w_next_ptr;
          if (w_req_win) begin
            r_q     <= w_wdata_win;
            r_owner <= r_winner;
            r_ack   <= w_win_oh;
            r_state <= CAPTURE;
          end else begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        end
        CAPTURE: begin
          r_ack <= '0;
          if (!w_req_win) begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end else begin
            r_state <= HOLD;
          end
        end
        HOLD: begin
          if (!w_req_win) begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: begin
          r_gnt   <= '0;
          r_ack   <= '0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  // qbar comes from the single q store, so q ^ qbar is all-ones by construction.
  assign gnt   = r_gnt;
  assign ack   = r_ack;
  assign q     = r_q;
  assign qbar  = ~r_q;
  assign owner = r_owner;
  assign busy  = r_busy;

endmodule

// File: tb/tb_dff_arbiter.sv
// Directed bench for dff_arbiter: table of transactions plus hold and reset sequences.
module tb_dff_arbiter;

  localparam int NREQ = 4;
  localparam int DW   = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req;
  logic [NREQ*DW-1:0] wdata;
  logic [NREQ-1:0]   gnt;
  logic [NREQ-1:0]   ack;
  logic [DW-1:0]     q;
  logic [DW-1:0]     qbar;
  logic [1:0]        owner;
  logic              busy;

  int n_checks = 0;
  int n_errors = 0;

  dff_arbiter #(
    .NREQ (NREQ),
    .DW   (DW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .wdata (wdata),
    .gnt   (gnt),
    .ack   (ack),
    .q     (q),
    .qbar  (qbar),
    .owner (owner),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Per-cycle invariants, sampled on the falling edge.
  logic [NREQ-1:0] prev_gnt = '0;
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      chk("inv q^qbar", 32'(q ^ qbar), 32'hFF);
      chk("inv gnt onehot0", 32'($onehot0(gnt)), 32'd1);
      chk("inv ack onehot0", 32'($onehot0(ack)), 32'd1);
      if (ack != '0) chk("inv ack after gnt", 32'(ack), 32'(prev_gnt));
      if (gnt != '0) chk("inv gnt implies busy", 32'(busy), 32'd1);
      prev_gnt = gnt;
    end else begin
      prev_gnt = '0;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic [3:0]  req;
    logic [31:0] wdata;
    bit          abort;
    logic [3:0]  exp_gnt;
    logic [7:0]  exp_q;
    logic [1:0]  exp_owner;
  } vec_t;

  vec_t vecs[10];

  initial begin
    vecs[0] = '{4'b0001, 32'h000000A5, 1'b0, 4'b0001, 8'hA5, 2'd0};
    vecs[1] = '{4'b1111, 32'h44332211, 1'b0, 4'b0010, 8'h22, 2'd1};
    vecs[2] = '{4'b1111, 32'h44332211, 1'b0, 4'b0100, 8'h33, 2'd2};
    vecs[3] = '{4'b1111, 32'h44332211, 1'b0, 4'b1000, 8'h44, 2'd3};
    vecs[4] = '{4'b1111, 32'h44332211, 1'b0, 4'b0001, 8'h11, 2'd0};
    vecs[5] = '{4'b0001, 32'h00000077, 1'b0, 4'b0001, 8'h77, 2'd0};
    vecs[6] = '{4'b0100, 32'h00EE0000, 1'b1, 4'b0100, 8'h77, 2'd0};
    vecs[7] = '{4'b0110, 32'h00005C00, 1'b0, 4'b0010, 8'h5C, 2'd1};
    vecs[8] = '{4'b1010, 32'hC3000000, 1'b0, 4'b1000, 8'hC3, 2'd3};
    vecs[9] = '{4'b1000, 32'h0F000000, 1'b0, 4'b1000, 8'h0F, 2'd3};

    rst_n = 1'b0;
    req   = '0;
    wdata = '0;
    #2;
    chk("reset gnt", 32'(gnt), 32'h0);
    chk("reset ack", 32'(ack), 32'h0);
    chk("reset q", 32'(q), 32'h00);
    chk("reset qbar", 32'(qbar), 32'hFF);
    chk("reset owner", 32'(owner), 32'h0);
    chk("reset busy", 32'(busy), 32'h0);
    tick();
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 10; i++) begin
      req   = vecs[i].req;
      wdata = vecs[i].wdata;
      tick();
      chk($sformatf("v%0d gnt", i), 32'(gnt), 32'(vecs[i].exp_gnt));
      chk($sformatf("v%0d busy", i), 32'(busy), 32'h1);
      chk($sformatf("v%0d ack early", i), 32'(ack), 32'h0);
      if (vecs[i].abort) begin
        req = '0;
        tick();
        chk($sformatf("v%0d abort gnt", i), 32'(gnt), 32'h0);
        chk($sformatf("v%0d abort ack", i), 32'(ack), 32'h0);
        chk($sformatf("v%0d abort busy", i), 32'(busy), 32'h0);
        chk($sformatf("v%0d abort q", i), 32'(q), 32'(vecs[i].exp_q));
        chk($sformatf("v%0d abort owner", i), 32'(owner), 32'(vecs[i].exp_owner));
      end else begin
        tick();
        chk($sformatf("v%0d ack", i), 32'(ack), 32'(vecs[i].exp_gnt));
        chk($sformatf("v%0d gnt off", i), 32'(gnt), 32'h0);
        chk($sformatf("v%0d q", i), 32'(q), 32'(vecs[i].exp_q));
        chk($sformatf("v%0d qbar", i), 32'(qbar), 32'(vecs[i].exp_q ^ 8'hFF));
        chk($sformatf("v%0d owner", i), 32'(owner), 32'(vecs[i].exp_owner));
        req = '0;
        tick();
        chk($sformatf("v%0d busy end", i), 32'(busy), 32'h0);
        chk($sformatf("v%0d ack end", i), 32'(ack), 32'h0);
      end
    end

    // Hold: requester 1 keeps req high; requester 3 must wait.
    req   = 4'b0010;
    wdata = 32'hE1009600;
    tick();
    chk("hold gnt", 32'(gnt), 32'b0010);
    tick();
    chk("hold ack", 32'(ack), 32'b0010);
    chk("hold q", 32'(q), 32'h96);
    req = 4'b1010;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk($sformatf("hold c%0d busy", c), 32'(busy), 32'h1);
      chk($sformatf("hold c%0d gnt", c), 32'(gnt), 32'h0);
      chk($sformatf("hold c%0d ack", c), 32'(ack), 32'h0);
    end
    req = 4'b1000;
    tick();
    chk("hold release busy", 32'(busy), 32'h0);
    chk("hold release gnt", 32'(gnt), 32'h0);
    tick();
    chk("hold next gnt", 32'(gnt), 32'b1000);
    tick();
    chk("hold next ack", 32'(ack), 32'b1000);
    chk("hold next q", 32'(q), 32'hE1);
    chk("hold next owner", 32'(owner), 32'd3);
    req = '0;
    tick();
    chk("hold done busy", 32'(busy), 32'h0);

    // Reset in CAPTURE: everything clears at once, arbitration restarts at ptr 0.
    req   = 4'b0100;
    wdata = 32'h003C0000;
    tick();
    chk("rst pre gnt", 32'(gnt), 32'b0100);
    tick();
    chk("rst pre ack", 32'(ack), 32'b0100);
    chk("rst pre q", 32'(q), 32'h3C);
    rst_n = 1'b0;
    #1;
    chk("rst q", 32'(q), 32'h00);
    chk("rst qbar", 32'(qbar), 32'hFF);
    chk("rst gnt", 32'(gnt), 32'h0);
    chk("rst ack", 32'(ack), 32'h0);
    chk("rst busy", 32'(busy), 32'h0);
    chk("rst owner", 32'(owner), 32'h0);
    req = '0;
    tick();
    tick();
    rst_n = 1'b1;
    req   = 4'b1010;
    tick();
    chk("post rst ptr0 gnt", 32'(gnt), 32'b0010);
    req = '0;
    tick();
    chk("post rst abort busy", 32'(busy), 32'h0);
    chk("post rst abort q", 32'(q), 32'h00);
    req   = 4'b1000;
    wdata = 32'h5A000000;
    tick();
    chk("post rst gnt", 32'(gnt), 32'b1000);
    tick();
    chk("post rst ack", 32'(ack), 32'b1000);
    chk("post rst q", 32'(q), 32'h5A);
    chk("post rst owner", 32'(owner), 32'd3);
    req = '0;
    tick();
    chk("post rst busy", 32'(busy), 32'h0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
